seg7_scan_driver: RTL and testbench

//   Consumer end of the 26-bit display word that the game controller produces.

---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/seg7_char_decode.sv | 15 +
 rtl/seg7_scan_driver.sv | 122 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 131 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and character map for the seg7 scan driver.
// Codes 0-9 are digits; A-F are glyphs G, b, U, blank, F and dash.
package seg7_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [3:0] CH_G     = 4'hA;
    localparam logic [3:0] CH_B     = 4'hB;
    localparam logic [3:0] CH_U     = 4'hC;
    localparam logic [3:0] CH_BLANK = 4'hD;
    localparam logic [3:0] CH_F     = 4'hE;
    localparam logic [3:0] CH_DASH  = 4'hF;

    localparam logic [23:0] BLANK_WORD = 24'hDDDDDD;

    // Segment pattern gfedcba, active-low, for one character code.
    function automatic logic [6:0] seg7_decode(input logic [3:0] code);
        logic [6:0] seg;
        unique case (code)
            4'h0:     seg = 7'h40;
            4'h1:     seg = 7'h79;
            4'h2:     seg = 7'h24;
            4'h3:     seg = 7'h30;
            4'h4:     seg = 7'h19;
            4'h5:     seg = 7'h12;
            4'h6:     seg = 7'h02;
            4'h7:     seg = 7'h78;
            4'h8:     seg = 7'h00;
            4'h9:     seg = 7'h10;
            CH_G:     seg = 7'h42;
            CH_B:     seg = 7'h03;
            CH_U:     seg = 7'h41;
            CH_BLANK: seg = 7'h7F;
            CH_F:     seg = 7'h0E;
            CH_DASH:  seg = 7'h3F;
            default:  seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational character decoder for the currently scanned digit.
// Pure lookup; the caller selects which code is presented.
module seg7_char_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg_n
);

    // Map the selected code to its active-low segment pattern.
    always_comb begin
        o_seg_n = seg7_decode(i_code);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Frame-snapshot, multiplexed six-digit common-anode 7-segment driver.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (suppress leading zeros).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int ON_CYCLES   = 50000,
    parameter int DP_POS      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] disp_word,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [5:0]  an_n,
    output logic        frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W:0]   ON_LIM    = (CNT_W+1)'(ON_CYCLES);
    localparam logic [2:0]       DIG_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [2:0]       DP_IDX    = 3'(DP_POS);

    logic [CNT_W-1:0] r_slot_cnt;
    logic [2:0]       r_digit_idx;
    logic [23:0]      r_snap;
    logic             r_dp_en;
    logic [6:0]       r_seg_n;
    logic             r_dp_n;
    logic [5:0]       r_an_n;
    logic             r_frame_start;

    logic             w_slot_end;
    logic             w_frame_end;
    logic             w_lit;
    logic [3:0]       w_code_raw;
    logic [3:0]       w_code_sel;
    logic [6:0]       w_seg_n;
    logic [5:0]       w_an_sel;
    logic             w_unused_bit;

    assign w_unused_bit = disp_word[24];

    assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_digit_idx == DIG_LAST);
    assign w_lit       = ({1'b0, r_slot_cnt} < ON_LIM);
    assign w_code_raw  = r_snap[{r_digit_idx, 2'b00} +: 4];
    assign w_an_sel    = ~(6'b000001 << r_digit_idx);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [5:0] w_suppress;
    logic       w_above_blank;

    // A zero left of the decimal-point digit goes dark while everything
    // above it is also zero or blank.
    always_comb begin
        w_suppress    = '0;
        w_above_blank = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (k > DP_POS && r_snap[4*k +: 4] == 4'h0 && w_above_blank)
                w_suppress[k] = 1'b1;
            w_above_blank = w_above_blank &&
                (r_snap[4*k +: 4] == 4'h0 || r_snap[4*k +: 4] == CH_BLANK);
        end
    end

    assign w_code_sel = w_suppress[r_digit_idx] ? CH_BLANK : w_code_raw;
`else
    assign w_code_sel = w_code_raw;
`endif

    seg7_char_decode u_decode (
        .i_code  (w_code_sel),
        .o_seg_n (w_seg_n)
    );

    // Slot timer and digit scan position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (w_slot_end) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == DIG_LAST) ? 3'd0 : r_digit_idx + 3'd1;
        end else begin
            r_slot_cnt  <= r_slot_cnt + 1'b1;
        end
    end

    // Capture the display word only at the frame boundary to avoid tearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap  <= BLANK_WORD;
            r_dp_en <= 1'b0;
        end else if (w_frame_end) begin
            r_snap  <= disp_word[23:0];
            r_dp_en <= disp_word[25];
        end
    end

    // Register pin outputs one cycle behind the scan position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_n       <= 7'h7F;
            r_dp_n        <= 1'b1;
            r_an_n        <= 6'h3F;
            r_frame_start <= 1'b0;
        end else begin
            r_seg_n       <= w_seg_n;
            r_dp_n        <= ~(r_dp_en && (r_digit_idx == DP_IDX));
            r_an_n        <= w_lit ? w_an_sel : 6'h3F;
            r_frame_start <= (r_digit_idx == 3'd0) && (r_slot_cnt == '0);
        end
    end

    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;
    assign an_n        = r_an_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver.
// Two instances: full duty (ON_CYCLES=4) and half duty (ON_CYCLES=2).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [25:0] disp_word;
    logic [6:0]  seg_n,  seg_n2;
    logic        dp_n,   dp_n2;
    logic [5:0]  an_n,   an_n2;
    logic        fs,     fs2;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(4), .ON_CYCLES(4), .DP_POS(3)) dut (
        .clk(clk), .rst(rst), .disp_word(disp_word),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_start(fs)
    );

    seg7_scan_driver #(.REFRESH_DIV(4), .ON_CYCLES(2), .DP_POS(3)) dut2 (
        .clk(clk), .rst(rst), .disp_word(disp_word),
        .seg_n(seg_n2), .dp_n(dp_n2), .an_n(an_n2), .frame_start(fs2)
    );

    typedef struct {
        string           name;
        logic            dp;
        logic [23:0]     word;
        logic [5:0][6:0] seg;
    } frame_t;

    frame_t     tab [4];
    logic [5:0] an_tab [6];

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    endtask

    task automatic set_word(input int e);
        disp_word = {tab[e].dp, 1'b0, tab[e].word};
    endtask

    // One 24-cycle frame; optionally change disp_word after cycle chg_at.
    task automatic frame_check(input int e, input int chg_at, input int chg_e);
        for (int t = 0; t < 24; t++) begin
            int d;
            int s;
            string p;
            d = t / 4;
            s = t % 4;
            p = $sformatf("%s d%0d s%0d", tab[e].name, d, s);
            @(negedge clk);
            chk({p, " seg"}, {1'b0, seg_n}, {1'b0, tab[e].seg[d]});
            chk({p, " an"}, {2'b0, an_n}, {2'b0, an_tab[d]});
            chk({p, " dp"}, {7'b0, dp_n},
                {7'b0, ~(tab[e].dp && d == 3)});
            chk({p, " fs"}, {7'b0, fs}, {7'b0, t == 0});
            chk({p, " seg2"}, {1'b0, seg_n2}, {1'b0, tab[e].seg[d]});
            chk({p, " an2"}, {2'b0, an_n2},
                {2'b0, (s < 2) ? an_tab[d] : 6'h3F});
            chk({p, " fs2"}, {7'b0, fs2}, {7'b0, t == 0});
            if (t == chg_at) set_word(chg_e);
        end
    endtask

    task automatic dark_check(input string n);
        chk({n, " seg"}, {1'b0, seg_n}, 8'h7F);
        chk({n, " an"}, {2'b0, an_n}, 8'h3F);
        chk({n, " dp"}, {7'b0, dp_n}, 8'h01);
        chk({n, " fs"}, {7'b0, fs}, 8'h00);
        chk({n, " an2"}, {2'b0, an_n2}, 8'h3F);
        chk({n, " seg2"}, {1'b0, seg_n2}, 8'h7F);
    endtask

    initial begin
        an_tab = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

        tab[0].name = "blank";
        tab[0].dp   = 1'b0;
        tab[0].word = 24'hDDDDDD;
        tab[0].seg  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

        tab[1].name = "w012345";
        tab[1].dp   = 1'b1;
        tab[1].word = 24'h012345;
        tab[1].seg  = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

        tab[2].name = "w888888";
        tab[2].dp   = 1'b1;
        tab[2].word = 24'h888888;
        tab[2].seg  = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

        tab[3].name = "w000120";
        tab[3].dp   = 1'b1;
        tab[3].word = 24'h000120;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        tab[3].seg  = {7'h7F, 7'h7F, 7'h40, 7'h79, 7'h24, 7'h40};
`else
        tab[3].seg  = {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40};
`endif

        rst = 1'b1;
        set_word(1);
        repeat (3) @(negedge clk);
        dark_check("reset");
        rst = 1'b0;

        frame_check(0, -1, 0);
        frame_check(1, 8, 2);
        frame_check(2, 0, 3);
        frame_check(3, -1, 0);

        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1 dark_check("midreset");
        @(negedge clk);
        rst = 1'b0;

        frame_check(0, -1, 0);
        frame_check(3, -1, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
